le_pipe: RTL and testbench

- WIDTH-bit registered logic element, the parametrised successor of the single-bit logic element.
- Adds four more logic ops (XOR/NAND/NOR/XNOR), a valid/ready handshake, a one-entry output register and an accumulator operand mode. The accumulator supports chained bitwise reductions.
- Sits between the operand/op decode stage and the ALU result mux in the CPLD ALU datapath.

---
 rtl/le_pipe.sv | 116 +++++++++++
 tb/tb_le_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/le_pipe.sv
// WIDTH-bit registered logic element with valid/ready handshake, a one-entry
// output register and an accumulator operand for chained bitwise reductions.
module le_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             m,
  input  logic [2:0]       s,
  input  logic             acc,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             zero,
  output logic             parity
);

  typedef enum logic [2:0] {
    OP_NOT_A  = 3'b000,
    OP_AND    = 3'b001,
    OP_PASS_A = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_NAND   = 3'b101,
    OP_NOR    = 3'b110,
    OP_XNOR   = 3'b111
  } op_e;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept_c;
  logic [WIDTH-1:0] op_b_c;
  logic [WIDTH-1:0] res_c;

  // A new op may enter when the output slot is empty or being drained this cycle.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // A clear coinciding with an accumulator-sourced op forces B to zero for that op.
  always_comb begin
    op_b_c = b;
    if (acc) begin
      op_b_c = acc_clr ? '0 : acc_q;
    end
  end

  always_comb begin
    res_c = a;
    if (!m) begin
      unique case (op_e'(s))
        OP_NOT_A:  res_c = ~a;
        OP_AND:    res_c = a & op_b_c;
        OP_PASS_A: res_c = a;
        OP_OR:     res_c = a | op_b_c;
        OP_XOR:    res_c = a ^ op_b_c;
        OP_NAND:   res_c = ~(a & op_b_c);
        OP_NOR:    res_c = ~(a | op_b_c);
        OP_XNOR:   res_c = ~(a ^ op_b_c);
        default:   res_c = a;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    x_d         = x_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    acc_d       = acc_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      x_d         = res_c;
      zero_d      = (res_c == '0);
      parity_d    = ^res_c;
      acc_d       = res_c;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_le_pipe.sv
// Scoreboard bench for le_pipe: the driver predicts each result with a truth-table
// model and queues it; a negedge monitor compares whatever the DUT presents.
module tb_le_pipe;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             m;
  logic [2:0]       s;
  logic             acc;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic             zero;
  logic             parity;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic             zero;
    logic             parity;
  } exp_t;

  exp_t sb[$];
  logic [3:0] tt [8];
  int n_checks = 0;
  int n_pass   = 0;
  logic             m_valid;
  logic [WIDTH-1:0] m_acc;

  le_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m),
    .s         (s),
    .acc       (acc),
    .acc_clr   (acc_clr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // Per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] ref_op(input logic mm, input logic [2:0] ss,
                                              input logic [WIDTH-1:0] aa,
                                              input logic [WIDTH-1:0] bb);
    logic [WIDTH-1:0] r;
    logic [3:0] row;
    if (mm) return aa;
    row = tt[ss];
    for (int i = 0; i < int'(WIDTH); i++) r[i] = row[{aa[i], bb[i]}];
    return r;
  endfunction

  function automatic logic ref_parity(input logic [WIDTH-1:0] v);
    int ones = 0;
    for (int i = 0; i < int'(WIDTH); i++) if (v[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic drive(input logic r, input logic iv, input logic ordy, input logic mm,
                       input logic [2:0] ss, input logic ac, input logic clr,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    logic er, accept;
    logic [WIDTH-1:0] opb, res;
    exp_t e;
    rst = r; in_valid = iv; out_ready = ordy; m = mm; s = ss;
    acc = ac; acc_clr = clr; a = aa; b = bb;
    #1;
    er = !r && (!m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    accept = iv && er;
    opb = ac ? (clr ? '0 : m_acc) : bb;
    res = ref_op(mm, ss, aa, opb);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_acc   = '0;
      sb.delete();
    end else if (accept) begin
      e.x      = res;
      e.zero   = (res == '0);
      e.parity = ref_parity(res);
      sb.push_back(e);
      m_acc   = res;
      m_valid = 1'b1;
    end else begin
      if (ordy) m_valid = 1'b0;
      if (clr)  m_acc   = '0;
    end
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_parity", 32'(parity), 32'd0);
  endtask

  // Monitor: compare the presented result; pop when the downstream consumes it.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb[0];
        chk("x", 32'(x), 32'(e.x));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("parity", 32'(parity), 32'(e.parity));
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1100; tt[3] = 4'b1110;
    tt[4] = 4'b0110; tt[5] = 4'b0111; tt[6] = 4'b0001; tt[7] = 4'b1001;
    m_valid = 1'b0;
    m_acc   = '0;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; m = 1'b0; s = 3'd0;
    acc = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
    @(posedge clk);
    #1;

    // Reset held for two cycles with a pending op
    drive(1, 1, 1, 0, 3'd3, 0, 0, 8'hAA, 8'h55);
    drive(1, 1, 1, 0, 3'd3, 0, 0, 8'hAA, 8'h55);
    check_reset_state();

    // Op sweep at full throughput
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 3'(i), 0, 0, 8'hC5, 8'h3A);
    drive(0, 1, 1, 1, 3'd1, 0, 0, 8'hC5, 8'h3A);
    drive(0, 0, 1, 0, 3'd0, 0, 0, 8'h00, 8'h00);

    // Backpressure: second op refused until out_ready rises
    drive(0, 1, 0, 0, 3'd3, 0, 0, 8'h0F, 8'hF0);
    drive(0, 1, 0, 0, 3'd1, 0, 0, 8'hFF, 8'h0F);
    drive(0, 1, 0, 0, 3'd1, 0, 0, 8'hFF, 8'h0F);
    drive(0, 1, 1, 0, 3'd1, 0, 0, 8'hFF, 8'h0F);
    drive(0, 0, 1, 0, 3'd0, 0, 0, 8'h00, 8'h00);

    // Accumulator chain
    drive(0, 1, 1, 0, 3'd3, 1, 1, 8'h01, 8'hEE);
    drive(0, 1, 1, 0, 3'd3, 1, 0, 8'h02, 8'hEE);
    drive(0, 1, 1, 0, 3'd4, 1, 0, 8'h04, 8'hEE);

    // Clear vs accept, then a standalone clear under backpressure
    drive(0, 1, 1, 0, 3'd2, 0, 0, 8'h55, 8'h00);
    drive(0, 1, 1, 0, 3'd1, 1, 1, 8'hFF, 8'h00);
    drive(0, 1, 1, 0, 3'd3, 1, 0, 8'h00, 8'hFF);
    drive(0, 1, 0, 0, 3'd2, 0, 0, 8'h55, 8'h00);
    drive(0, 0, 0, 0, 3'd0, 0, 1, 8'h00, 8'h00);
    drive(0, 1, 1, 0, 3'd3, 1, 0, 8'h00, 8'h00);
    drive(0, 0, 1, 0, 3'd0, 0, 0, 8'h00, 8'h00);

    // Reset while a result is stalled
    drive(0, 1, 0, 0, 3'd2, 0, 0, 8'hAA, 8'h00);
    drive(0, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 0, 3'd0, 0, 0, 8'h00, 8'h00);
    check_reset_state();
    drive(0, 1, 1, 0, 3'd3, 1, 0, 8'h5C, 8'hFF);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0),
            3'($urandom), 1'($urandom), logic'($urandom_range(0, 5) == 0),
            8'($urandom), 8'($urandom));
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 3'd0, 0, 0, 8'h00, 8'h00);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
